// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: ramps the PWM duty toward a commanded target one step per N periods, with emergency stop.
module pwm_ramp_ctrl #(
  parameter logic [6:0] STEP         = 7'd5,
  parameter logic [7:0] RAMP_PERIODS = 8'd4,
  parameter logic [6:0] MAX_DUTY     = 7'd100
) (
  input  logic       i_clk,
  input  logic       i_clr_n,
  input  logic       i_cmd_valid,
  input  logic [6:0] i_cmd_duty,
  output logic       o_cmd_ready,
  input  logic       i_period_end,
  input  logic       i_estop,
  output logic [6:0] o_duty_cycle,
  output logic       o_load,
  output logic       o_busy,
  output logic       o_at_target,
  output logic       o_stopped
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RAMP = 2'd1;
  localparam logic [1:0] STOP = 2'd2;
  localparam logic [7:0] RP_LAST = (RAMP_PERIODS == 8'd0) ? 8'd0 : RAMP_PERIODS - 8'd1;
  logic [1:0] r_state;
  logic [6:0] r_target;
  logic [6:0] r_duty;
  logic [7:0] r_pcount;
  logic       r_load;
  logic       w_accept;
  logic [6:0] w_eff;
  logic       w_up;
  logic [7:0] w_diff;
  logic [6:0] w_next;
  logic       w_step;
  always_comb begin
    w_accept = i_cmd_valid && !i_estop;
    w_eff    = w_accept ? ((i_cmd_duty > MAX_DUTY) ? MAX_DUTY : i_cmd_duty) : r_target;
    w_up     = w_eff > r_duty;
    w_diff   = w_up ? {1'b0, w_eff} - {1'b0, r_duty} : {1'b0, r_duty} - {1'b0, w_eff};
    w_next   = (w_diff <= {1'b0, STEP}) ? w_eff : w_up ? r_duty + STEP : r_duty - STEP;
    w_step   = (r_state == RAMP) && i_period_end && (r_pcount == RP_LAST);
  end
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_state  <= IDLE;
      r_target <= 7'd0;
      r_duty   <= 7'd0;
      r_pcount <= 8'd0;
      r_load   <= 1'b0;
    end else if (i_estop) begin
      r_state  <= STOP;
      r_target <= 7'd0;
      r_duty   <= 7'd0;
      r_pcount <= 8'd0;
      r_load   <= (r_duty != 7'd0) || (r_state != STOP);
    end else begin
      r_load <= 1'b0;
      if (w_accept) r_target <= w_eff;
      if (r_state == IDLE) begin
        if (w_accept && w_eff != r_duty) begin
          r_state  <= RAMP;
          r_pcount <= 8'd0;
        end
      end else if (r_state == RAMP) begin
        if (w_step) begin
          r_duty   <= w_next;
          r_load   <= 1'b1;
          r_pcount <= 8'd0;
          if (w_next == w_eff) r_state <= IDLE;
        end else begin
          if (i_period_end) r_pcount <= r_pcount + 8'd1;
          if (w_accept && w_eff == r_duty) r_state <= IDLE;
        end
      end else if (w_accept) begin
        r_state  <= (w_eff != 7'd0) ? RAMP : IDLE;
        r_pcount <= 8'd0;
      end
    end
  end
  assign o_cmd_ready  = !i_estop;
  assign o_duty_cycle = r_duty;
  assign o_load       = r_load;
  assign o_busy       = r_state == RAMP;
  assign o_at_target  = r_state == IDLE;
  assign o_stopped    = r_state == STOP;
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed stimulus; expected duty per load pulse queued and checked by a monitor.
module tb_pwm_ramp_ctrl;
  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [6:0] cmd_duty = 7'd0;
  logic       cmd_ready;
  logic       period_end = 1'b0;
  logic       estop = 1'b0;
  logic [6:0] duty_cycle;
  logic       load;
  logic       busy;
  logic       at_target;
  logic       stopped;
  int         n_tests = 0;
  int         n_fail = 0;
  int         exp_q[$];
  pwm_ramp_ctrl #(.STEP(7'd5), .RAMP_PERIODS(8'd2), .MAX_DUTY(7'd100)) dut (
    .i_clk(clk), .i_clr_n(clr_n), .i_cmd_valid(cmd_valid), .i_cmd_duty(cmd_duty),
    .o_cmd_ready(cmd_ready), .i_period_end(period_end), .i_estop(estop),
    .o_duty_cycle(duty_cycle), .o_load(load), .o_busy(busy),
    .o_at_target(at_target), .o_stopped(stopped)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (load) begin
      if (exp_q.size() == 0) check("unexpected_load", 1, 0);
      else check("load_duty", int'(duty_cycle), exp_q.pop_front());
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pe();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
    tick();
  endtask
  task automatic cmd(input logic [6:0] d);
    cmd_valid = 1'b1;
    cmd_duty = d;
    tick();
    cmd_valid = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    check("rst_duty", duty_cycle, 0);
    check("rst_load", load, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_at_target", at_target, 1);
    check("rst_stopped", stopped, 0);
    clr_n = 1'b1;
    tick();
    // ramp up 0 -> 23
    exp_q.push_back(5); exp_q.push_back(10); exp_q.push_back(15);
    exp_q.push_back(20); exp_q.push_back(23);
    cmd(7'd23);
    check("up_busy", busy, 1);
    for (int i = 0; i < 10; i++) pe();
    check("up_duty", duty_cycle, 23);
    check("up_at_target", at_target, 1);
    // clamp 120 -> 100
    for (int i = 1; i <= 16; i++) exp_q.push_back((23 + 5 * i > 100) ? 100 : 23 + 5 * i);
    cmd(7'd120);
    for (int i = 0; i < 32; i++) pe();
    check("clamp_duty", duty_cycle, 100);
    check("clamp_at_target", at_target, 1);
    // retarget mid-ramp keeps pcount
    exp_q.push_back(95); exp_q.push_back(90); exp_q.push_back(85); exp_q.push_back(80);
    cmd(7'd7);
    pe(); pe();
    pe();
    cmd(7'd80);
    check("retarget_busy", busy, 1);
    pe();
    check("retarget_step", duty_cycle, 90);
    pe(); pe(); pe(); pe();
    check("retarget_duty", duty_cycle, 80);
    check("retarget_idle", at_target, 1);
    // simultaneous step and accept
    exp_q.push_back(85); exp_q.push_back(87);
    cmd(7'd100);
    pe(); pe();
    pe();
    cmd_valid = 1'b1; cmd_duty = 7'd87; period_end = 1'b1;
    tick();
    cmd_valid = 1'b0; period_end = 1'b0;
    check("sim_duty", duty_cycle, 87);
    check("sim_idle", at_target, 1);
    tick();
    // no-op command and period_end ignored in IDLE
    cmd(7'd87);
    check("noop_idle", at_target, 1);
    check("noop_busy", busy, 0);
    pe(); pe(); pe();
    check("noop_duty", duty_cycle, 87);
    // emergency stop mid-ramp
    exp_q.push_back(82); exp_q.push_back(0);
    cmd(7'd20);
    pe(); pe();
    pe();
    estop = 1'b1;
    tick();
    check("estop_duty", duty_cycle, 0);
    check("estop_stopped", stopped, 1);
    check("estop_ready", cmd_ready, 0);
    check("estop_load", load, 1);
    pe(); pe();
    check("estop_hold_load", load, 0);
    estop = 1'b0;
    tick();
    check("stop_stay", stopped, 1);
    check("stop_ready", cmd_ready, 1);
    pe();
    check("stop_pe_stay", stopped, 1);
    exp_q.push_back(5); exp_q.push_back(10);
    cmd(7'd50);
    check("stop_exit_busy", busy, 1);
    check("stop_exit_stopped", stopped, 0);
    for (int i = 0; i < 4; i++) pe();
    check("resume_duty", duty_cycle, 10);
    // reset mid-ramp at duty 35
    for (int i = 3; i <= 7; i++) exp_q.push_back(5 * i);
    for (int i = 0; i < 10; i++) pe();
    check("pre_rst_duty", duty_cycle, 35);
    pe();
    clr_n = 1'b0;
    tick();
    check("midrst_duty", duty_cycle, 0);
    check("midrst_load", load, 0);
    check("midrst_at_target", at_target, 1);
    check("midrst_busy", busy, 0);
    clr_n = 1'b1;
    tick(); tick();
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
